alu_issue_queue: RTL and testbench

Upstream feeder for the ALU. Accepts tagged commands (A, B, Opcode) over a valid/ready handshake and buffers them in a small FIFO. It drops reserved opcodes at entry and issues at most one command per cycle onto the ALU operand/opcode inputs. It also produces a response-valid/tag strobe aligned to the cycle in which the ALU's registered Result and Error belong to that command.

---
 rtl/alu_issue_queue.sv | 104 ++++++++++
 tb/tb_alu_issue_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Tagged-command FIFO that feeds the ALU one command per cycle.
// Reserved opcodes are dropped at entry. A response strobe is aligned to the ALU's registered result.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     stall,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_opcode,
  output logic                     issue_valid,
  output logic                     rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] OP_IDLE = 3'b010;
  localparam logic [2:0] OP_MAX  = 3'b100;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [TAG_W-1:0] issue_tag;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;

  // in_ready deliberately ignores a same-edge pop: a full queue never accepts.
  assign in_ready = rst & (count != FULL);
  assign accept   = in_valid & in_ready;
  assign push     = accept & (in_op <= OP_MAX);
  assign drop     = accept & (in_op > OP_MAX);
  assign pop      = (count != '0) & ~stall;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= OP_IDLE;
      issue_valid <= 1'b0;
      issue_tag   <= '0;
      rsp_valid   <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (drop && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 8'd1;

      issue_valid <= pop;
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
        issue_tag  <= head.tag;
      end else begin
        // Idle slots drive AND of zeros so the ALU never flags an error.
        alu_a      <= '0;
        alu_b      <= '0;
        alu_opcode <= OP_IDLE;
      end

      rsp_valid <= issue_valid;
      rsp_tag   <= issue_tag;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: the driver pushes expected issues into a queue, and a monitor pops and checks them.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        stall = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic        issue_valid;
  logic        rsp_valid;
  logic [3:0]  rsp_tag;
  logic [2:0]  count;
  logic [7:0]  illegal_cnt;

  alu_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag), .stall(stall),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .issue_valid(issue_valid), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
  } cmd_t;

  cmd_t exp_q[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Offer one command, hold it until accepted; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int unsigned n = 0;
    logic rdy;
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    while (!done) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk);
      if (rdy === 1'b1) begin
        done = 1;
        if (op <= 3'b100) exp_q.push_back('{a: a, b: b, op: op, tag: tag});
      end else if (++n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    do begin
      @(negedge clk); n++;
    end while ((count != 0 || issue_valid || rsp_valid) && n < 100);
    check({name, "_count"}, count, 0);
    check({name, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [3:0] tag);
    send(32'd5, 32'd3, 3'b000, tag);
    @(negedge clk);
    check("lat_count1", count, 1);
    check("lat_issue_early", issue_valid, 0);
    @(negedge clk);
    check("lat_issue", issue_valid, 1);
    check("lat_alu_a", alu_a, 5);
    check("lat_alu_b", alu_b, 3);
    check("lat_opcode", alu_opcode, 3'b000);
    @(negedge clk);
    check("lat_rsp_valid", rsp_valid, 1);
    check("lat_rsp_tag", rsp_tag, tag);
    @(posedge clk); #1;
  endtask

  // Monitor: checks every cycle's issue/response against the scoreboard.
  logic r_edge;
  logic prev_issue = 1'b0;
  logic [3:0] prev_tag = '0;
  cmd_t e;
  initial begin
    forever begin
      @(posedge clk); r_edge = rst;
      @(negedge clk);
      if (r_edge !== 1'b1) begin
        exp_q.delete();
        check("rst_issue", issue_valid, 0);
        check("rst_rsp", rsp_valid, 0);
        prev_issue = 1'b0;
      end else begin
        check("rsp_align", rsp_valid, prev_issue);
        if (prev_issue) check("rsp_tag", rsp_tag, prev_tag);
        if (issue_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("issue_a", alu_a, e.a);
            check("issue_b", alu_b, e.b);
            check("issue_op", alu_opcode, e.op);
            prev_tag = e.tag;
          end
        end else begin
          check("idle_drive", {alu_a | alu_b, 1'b0} ^ {32'd0, alu_opcode}, 3'b010);
        end
        prev_issue = issue_valid;
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_illegal", illegal_cnt, 0);
    check("rst_opcode", alu_opcode, 3'b010);
    check("rst_alu_a", alu_a, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single command latency
    single(4'd1);
    drain("single");

    // Fill while stalled; 5th command held by producer
    stall = 1'b1;
    fork
      for (int i = 0; i < 5; i++) send(32'd100 + i, 32'd7 * i, 3'(i % 5), 4'(2 + i));
      begin
        repeat (6) @(negedge clk);
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        @(posedge clk); #1 stall = 1'b0;
      end
    join
    drain("fill");

    // Reserved opcode between legal commands
    send(32'hA, 32'hB, 3'b001, 4'd8);
    send(32'hDEAD, 32'hBEEF, 3'b110, 4'd7);
    send(32'hC, 32'hD, 3'b011, 4'd9);
    drain("reserved");
    check("illegal_one", illegal_cnt, 1);

    // Full with pop: no push at full, then push+pop holds count; wrap order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h1000 + i, 32'h2000 + i, 3'b100, 4'(i));
    stall = 1'b0;
    fork
      for (int i = 0; i < 20; i++)
        send(32'h3000 + 32'(i * 3), 32'(i), 3'(i % 5), 4'(i % 16));
      begin
        @(negedge clk); check("pp_count4", count, 4);
        @(negedge clk); check("pp_count3a", count, 3);
        @(negedge clk); check("pp_count3b", count, 3);
      end
    join
    drain("wrap");

    // Idle drive
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_opcode", alu_opcode, 3'b010);
      check("idle_issue", issue_valid, 0);
    end
    @(posedge clk); #1;

    // Saturating illegal counter: 1 + 260 drops
    for (int i = 0; i < 260; i++) send(32'(i), 32'(i), 3'(5 + i % 3), 4'(i % 16));
    @(negedge clk);
    check("illegal_sat", illegal_cnt, 255);
    check("illegal_no_push", count, 0);
    @(posedge clk); #1;

    // Reset mid-flight: 3 queued, 1 issued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h50 + i, 32'h60 + i, 3'b000, 4'(10 + i));
    stall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_issue_before", issue_valid, 1);
    check("mid_count_before", count, 3);
    @(negedge clk);
    check("mid_count", count, 0);
    check("mid_issue", issue_valid, 0);
    check("mid_rsp", rsp_valid, 0);
    check("mid_opcode", alu_opcode, 3'b010);
    check("mid_illegal", illegal_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;
    single(4'd15);
    drain("final");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
